// File: rtl/fhe_alu_pkg.sv
// Shared FHE ALU constants and the root-power bank state encoding.
package fhe_alu_pkg;

    localparam int NTT_INTT_NUM   = 4;
    localparam int ROOT_POWER_NUM = 4;
    localparam int N              = 256;
    localparam int E              = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } bank_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/root_bank_fsm.sv
// One root-power bank: round-robin pick among requesters targeting this bank,
// then ACTIVE for the burst length and DRAIN for the interconnect pipeline.
module root_bank_fsm #(
    parameter int NTT_INTT_NUM = 4,
    parameter int BANK_W       = 2,
    parameter int REQ_W        = 2,
    parameter int LEN_W        = 6,
    parameter int DRAIN_CYCLES = 2,
    parameter int BANK_ID      = 0
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [NTT_INTT_NUM-1:0]               req_valid,
    input  logic [NTT_INTT_NUM-1:0][BANK_W-1:0]   req_bank,
    input  logic [NTT_INTT_NUM-1:0][LEN_W-1:0]    req_len,
    input  logic [NTT_INTT_NUM-1:0]               ready_any,
    output logic [NTT_INTT_NUM-1:0]               ready,
    output logic [NTT_INTT_NUM-1:0]               active,
    output logic [NTT_INTT_NUM-1:0]               done,
    output logic [NTT_INTT_NUM-1:0]               routed,
    output logic [REQ_W-1:0]                      owner,
    output logic                                  busy
);
    import fhe_alu_pkg::*;

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    bank_state_e              state_q, state_d;
    logic [LEN_W-1:0]         count_q, count_d;
    logic [DRAIN_W-1:0]       drain_q, drain_d;
    logic [REQ_W-1:0]         ptr_q, ptr_d, owner_d, winner;
    logic [NTT_INTT_NUM-1:0]  cand, ready_c;
    logic                     found, done_q;

    always_comb begin
        for (int r = 0; r < NTT_INTT_NUM; r++)
            cand[r] = req_valid[r] && (req_bank[r] == BANK_W'(BANK_ID));
    end

    // Scan starts at the requester after the previous owner.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NTT_INTT_NUM; i++) begin
            if (!found && cand[(int'(ptr_q) + i) % NTT_INTT_NUM]) begin
                found  = 1'b1;
                winner = REQ_W'((int'(ptr_q) + i) % NTT_INTT_NUM);
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        drain_d = drain_q;
        ptr_d   = ptr_q;
        owner_d = owner;
        ready_c = '0;
        unique case (state_q)
            IDLE: if (found) begin
                ready_c[winner] = 1'b1;
                owner_d = winner;
                count_d = (req_len[winner] == '0) ? '0 : req_len[winner] - LEN_W'(1);
                ptr_d   = (winner == REQ_W'(NTT_INTT_NUM - 1)) ? '0 : winner + REQ_W'(1);
                state_d = ACTIVE;
            end
            ACTIVE: begin
                if (count_q == '0) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                        drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
                    end
                end else begin
                    count_d = count_q - LEN_W'(1);
                end
            end
            DRAIN: begin
                if (drain_q == '0) state_d = IDLE;
                else               drain_d = drain_q - DRAIN_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            count_q <= '0;
            drain_q <= '0;
            ptr_q   <= '0;
            owner   <= '0;
            done_q  <= 1'b0;
            routed  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            drain_q <= drain_d;
            ptr_q   <= ptr_d;
            owner   <= owner_d;
            done_q  <= (state_q == ACTIVE) && (count_q == '0);
            routed  <= (routed & ~ready_any) | ready_c;
        end
    end

    // Ready is combinational from inputs, so it is forced low while reset is held.
    assign ready = rstn ? ready_c : '0;
    assign busy  = (state_q != IDLE);

    always_comb begin
        active = '0;
        done   = '0;
        if (state_q == ACTIVE) active[owner] = 1'b1;
        if (done_q)            done[owner]   = 1'b1;
    end

endmodule

// File: rtl/root_access_arbiter.sv
// Routes NTT/INTT requesters to root-power banks; one independent FSM per bank,
// per-requester outputs are the OR of all bank contributions.
module root_access_arbiter #(
    parameter int NTT_INTT_NUM   = fhe_alu_pkg::NTT_INTT_NUM,
    parameter int ROOT_POWER_NUM = fhe_alu_pkg::ROOT_POWER_NUM,
    parameter int LEN_W          = $clog2(fhe_alu_pkg::N / (fhe_alu_pkg::E / 2)) + 1,
    parameter int DRAIN_CYCLES   = 2,
    localparam int BANK_W        = fhe_alu_pkg::idx_width(ROOT_POWER_NUM),
    localparam int REQ_W         = fhe_alu_pkg::idx_width(NTT_INTT_NUM)
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic [NTT_INTT_NUM-1:0]                 req_valid,
    input  logic [NTT_INTT_NUM-1:0][BANK_W-1:0]     req_bank,
    input  logic [NTT_INTT_NUM-1:0][LEN_W-1:0]      req_len,
    output logic [NTT_INTT_NUM-1:0]                 req_ready,
    output logic [NTT_INTT_NUM-1:0]                 grant_active,
    output logic [NTT_INTT_NUM-1:0]                 done,
    output logic [NTT_INTT_NUM-1:0][BANK_W-1:0]     root_select,
    output logic [ROOT_POWER_NUM-1:0][REQ_W-1:0]    ntt_intt_select,
    output logic [ROOT_POWER_NUM-1:0]               bank_busy
);

    logic [ROOT_POWER_NUM-1:0][NTT_INTT_NUM-1:0] bank_ready, bank_active, bank_done, bank_routed;

    for (genvar b = 0; b < ROOT_POWER_NUM; b++) begin : g_bank
        root_bank_fsm #(
            .NTT_INTT_NUM (NTT_INTT_NUM),
            .BANK_W       (BANK_W),
            .REQ_W        (REQ_W),
            .LEN_W        (LEN_W),
            .DRAIN_CYCLES (DRAIN_CYCLES),
            .BANK_ID      (b)
        ) u_bank (
            .clk       (clk),
            .rstn      (rstn),
            .req_valid (req_valid),
            .req_bank  (req_bank),
            .req_len   (req_len),
            .ready_any (req_ready),
            .ready     (bank_ready[b]),
            .active    (bank_active[b]),
            .done      (bank_done[b]),
            .routed    (bank_routed[b]),
            .owner     (ntt_intt_select[b]),
            .busy      (bank_busy[b])
        );
    end

    // Only one bank at a time marks a requester as routed, so OR-ing indices is exact.
    always_comb begin
        req_ready    = '0;
        grant_active = '0;
        done         = '0;
        root_select  = '0;
        for (int b = 0; b < ROOT_POWER_NUM; b++) begin
            req_ready    = req_ready    | bank_ready[b];
            grant_active = grant_active | bank_active[b];
            done         = done         | bank_done[b];
            for (int r = 0; r < NTT_INTT_NUM; r++)
                if (bank_routed[b][r]) root_select[r] = root_select[r] | BANK_W'(b);
        end
    end

endmodule

// File: doc/root_access_arbiter.md
ROOT_ACCESS_ARBITER -- requirements
Module: root_access_arbiter

Interface
REQ-001 Parameter NTT_INTT_NUM, default 4, number of NTT/INTT requesters.
REQ-002 Parameter ROOT_POWER_NUM, default 4, number of root-power banks.
REQ-003 Parameter LEN_W, default $clog2(N/(E/2))+1, width of a burst length.
REQ-004 Parameter DRAIN_CYCLES, default 2, interconnect pipeline depth held after each burst.
REQ-005 One clock; reset is asynchronous and active-low. Ports are clk and rstn.
REQ-006 clk  in  1  system clock.
REQ-007 rstn  in  1  async active-low reset.
REQ-008 req_valid  in  [NTT_INTT_NUM]  requester wants a bank.
REQ-009 req_bank  in  [NTT_INTT_NUM][$clog2(ROOT_POWER_NUM)]  target bank.
REQ-010 req_len  in  [NTT_INTT_NUM][LEN_W]  burst length in address beats.
REQ-011 req_ready  out  [NTT_INTT_NUM]  request accepted this cycle.
REQ-012 grant_active  out  [NTT_INTT_NUM]  requester may issue root-power read addresses.
REQ-013 done  out  [NTT_INTT_NUM]  one-cycle burst-complete pulse.
REQ-014 root_select  out  [NTT_INTT_NUM][$clog2(ROOT_POWER_NUM)]  bank routed to each requester.
REQ-015 ntt_intt_select  out  [ROOT_POWER_NUM][$clog2(NTT_INTT_NUM)]  requester routed to each bank.
REQ-016 bank_busy  out  [ROOT_POWER_NUM]  bank is not IDLE.

Function
REQ-017 Each bank SHALL run an independent FSM with states IDLE, ACTIVE and DRAIN.
REQ-018 IDLE: if any requester has req_valid=1 and req_bank=b, bank b SHALL pick one winner round-robin, starting from (last owner+1) mod NTT_INTT_NUM. The pointer resets to requester 0 first.
REQ-019 req_ready[winner] SHALL be combinational and high in the IDLE cycle. At that edge: owner latched, count=max(req_len,1)-1, state=ACTIVE.
REQ-020 ACTIVE: grant_active[owner]=1 for exactly max(req_len,1) cycles. The count decrements each cycle. count==0 -> DRAIN.
REQ-021 DRAIN: lasts DRAIN_CYCLES cycles. done[owner]=1 in the first DRAIN cycle only, then -> IDLE.
REQ-022 DRAIN_CYCLES=0: ACTIVE goes directly to IDLE. done is asserted in the cycle after the last ACTIVE cycle.
REQ-023 ntt_intt_select[b] SHALL equal owner from the cycle after acceptance through the last DRAIN cycle. Outside that window it holds its last value.
REQ-024 root_select[owner] SHALL equal b over the same window. Outside that window it holds its last value.
REQ-025 req_len=0 SHALL be treated as 1.
REQ-026 Losing requesters keep req_valid high and receive no req_ready. Requests are never dropped.
REQ-027 Requests for different banks SHALL be granted in the same cycle, independently.
REQ-028 A requester SHALL hold req_valid, req_bank and req_len stable until req_ready.
REQ-029 A requester SHALL keep req_valid low while grant_active or done is pending. Violation is undefined; the bench checks it with an assertion.
REQ-030 A new grant on a bank SHALL NOT be issued before its DRAIN ends. Minimum spacing between acceptances is len+DRAIN_CYCLES+1 cycles.
REQ-031 bank_busy[b]=1 in ACTIVE and DRAIN.

Reset
REQ-032 On rstn=0, all bank FSMs go to IDLE and all count/owner/pointer registers go to 0.
REQ-033 During reset, req_ready, grant_active, done, bank_busy, root_select and ntt_intt_select are all 0.
REQ-034 Reset mid-burst aborts the burst with no done pulse. Operation resumes on the first edge after deassertion.

Structure
REQ-035 NTT_INTT_NUM, ROOT_POWER_NUM, N and E come from FHE_ALU_PKG. The bank-state enum typedef (IDLE/ACTIVE/DRAIN) SHALL be added to FHE_ALU_PKG.
REQ-036 One sub-module, root_bank_fsm, SHALL implement a single bank: FSM, counter, owner and round-robin pointer. It is instantiated ROOT_POWER_NUM times.
REQ-037 The top level SHALL OR-reduce per-bank ready/active/done/select contributions per requester. It contains no other state.

Verification
REQ-038 Single request: r0, bank 2, len 5 -> req_ready[0] at t0; grant_active[0] t1..t5; done[0] at t6; root_select[0]=2 and ntt_intt_select[2]=0 for t1..t7; IDLE at t8.
REQ-039 Contention: r0..r3 all request bank 1, len 3, at t0 -> grant order 0,1,2,3; acceptances 6 cycles apart; each ntt_intt_select[1] value held through its own DRAIN.
REQ-040 Parallel banks: r0->bank 0 (len 4) and r1->bank 3 (len 2) at t0 -> both ready at t0; done[1] at t3; done[0] at t5.
REQ-041 Boundaries: len=0 behaves as len=1. Max len 2**LEN_W-1 completes without wrap. The round-robin pointer wraps 3->0.
REQ-042 Reset: rstn low at t3 of a len-8 burst -> all outputs 0 immediately and no done pulse. A fresh request after release is accepted with the pointer at 0.
